// File: rtl/demux16_pkg.sv
// Shared lane constants and types for the 1-to-16 dispatch demultiplexer.
package demux16_pkg;

  localparam int unsigned NUM_LANES = 16;
  localparam int unsigned SEL_W     = 4;

  typedef logic [SEL_W-1:0]     lane_idx_t;
  typedef logic [NUM_LANES-1:0] lane_mask_t;

  function automatic lane_mask_t sel_onehot(lane_idx_t sel);
    lane_mask_t mask;
    mask      = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry holding register for a single output lane; load wins over drain.
module demux_lane_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             drain_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (load_i) begin
      vld_d  = 1'b1;
      data_d = din_i;
    end else if (drain_i) begin
      // Data is left in place after a drain; only the valid flag drops.
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/demux16_dispatch.sv
// Registered 1-to-16 valid/ready demultiplexer with per-lane holding registers.
// Optional broadcast to all lanes is enabled by defining DEMUX16_BCAST_EN.
module demux16_dispatch
  import demux16_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic [SEL_W-1:0]           in_sel,
  input  logic [WIDTH-1:0]           in_data,
  output logic [NUM_LANES-1:0]       out_vld,
  input  logic [NUM_LANES-1:0]       out_rdy,
  output logic [NUM_LANES*WIDTH-1:0] out_data,
`ifdef DEMUX16_BCAST_EN
  input  logic                       in_bcast,
`endif
  output logic [CNT_W-1:0]           disp_cnt
);

  lane_mask_t       lane_free;
  lane_mask_t       load_mask;
  lane_mask_t       drain_mask;
  logic             accept;
  logic [CNT_W-1:0] disp_cnt_q, disp_cnt_d;

  // A full lane that drains this cycle may be refilled in the same cycle.
  assign lane_free  = ~out_vld | out_rdy;
  assign drain_mask = out_vld & out_rdy;
  assign accept     = in_vld & in_rdy;

  always_comb begin
    load_mask = '0;
`ifdef DEMUX16_BCAST_EN
    in_rdy = in_bcast ? (&lane_free) : lane_free[in_sel];
    if (accept) begin
      load_mask = in_bcast ? '1 : sel_onehot(lane_idx_t'(in_sel));
    end
`else
    in_rdy = lane_free[in_sel];
    if (accept) begin
      load_mask = sel_onehot(lane_idx_t'(in_sel));
    end
`endif
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demux_lane_reg #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk_i  (clk),
      .rst_i  (rst),
      .load_i (load_mask[i]),
      .drain_i(drain_mask[i]),
      .din_i  (in_data),
      .vld_o  (out_vld[i]),
      .data_o (out_data[i*WIDTH +: WIDTH])
    );
  end

  always_comb begin
    disp_cnt_d = disp_cnt_q;
    if (accept) begin
      disp_cnt_d = disp_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_cnt_q <= '0;
    end else begin
      disp_cnt_q <= disp_cnt_d;
    end
  end

  assign disp_cnt = disp_cnt_q;

endmodule

// File: tb/tb_demux16_dispatch.sv
// Directed self-checking bench for demux16_dispatch (broadcast cases under DEMUX16_BCAST_EN).
module tb_demux16_dispatch;

  logic        clk;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [3:0]  in_sel;
  logic [3:0]  in_data;
  logic [15:0] out_vld;
  logic [15:0] out_rdy;
  logic [63:0] out_data;
  logic [15:0] disp_cnt;
  logic        in_bcast;

  int unsigned n_checks;
  int unsigned n_fails;

  demux16_dispatch #(
    .WIDTH(4),
    .CNT_W(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .in_sel  (in_sel),
    .in_data (in_data),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_data(out_data),
`ifdef DEMUX16_BCAST_EN
    .in_bcast(in_bcast),
`endif
    .disp_cnt(disp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge so registered outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] lane(input logic [63:0] d, input int s);
    return d[s*4 +: 4];
  endfunction

  initial begin
    n_checks = 0;
    n_fails  = 0;
    in_bcast = 1'b0;

    // Reset held with a valid beat pending
    rst     = 1'b1;
    in_vld  = 1'b1;
    in_sel  = 4'd5;
    in_data = 4'hF;
    out_rdy = 16'h0000;
    tick();
    tick();
    check("reset_vld", 64'(out_vld), 64'h0);
    check("reset_data", out_data, 64'h0);
    check("reset_cnt", 64'(disp_cnt), 64'h0);
    rst    = 1'b0;
    in_vld = 1'b0;
    tick();
    check("post_reset_vld", 64'(out_vld), 64'h0);

    // Single route to lane 5
    in_sel  = 4'd5;
    in_data = 4'hA;
    in_vld  = 1'b1;
    #1;
    check("route_rdy", 64'(in_rdy), 64'h1);
    tick();
    in_vld = 1'b0;
    check("route_vld", 64'(out_vld), 64'h0020);
    check("route_data", 64'(out_data[23:20]), 64'hA);
    check("route_cnt", 64'(disp_cnt), 64'd1);

    // Backpressure on lane 5
    in_sel  = 4'd5;
    in_data = 4'h3;
    in_vld  = 1'b1;
    #1;
    check("bp_rdy_low", 64'(in_rdy), 64'h0);
    tick();
    check("bp_hold_data", 64'(lane(out_data, 5)), 64'hA);
    check("bp_hold_cnt", 64'(disp_cnt), 64'd1);
    out_rdy = 16'h0020;
    #1;
    check("bp_rdy_high", 64'(in_rdy), 64'h1);
    tick();
    in_vld  = 1'b0;
    out_rdy = 16'h0000;
    check("bp_refill_data", 64'(lane(out_data, 5)), 64'h3);
    check("bp_refill_vld", 64'(out_vld), 64'h0020);
    check("bp_refill_cnt", 64'(disp_cnt), 64'd2);
    out_rdy = 16'hFFFF;
    tick();
    check("drain_vld", 64'(out_vld), 64'h0);
    check("drain_keep_data", 64'(lane(out_data, 5)), 64'h3);

    // Back-to-back streaming across all lanes
    for (int s = 0; s < 16; s++) begin
      in_sel  = 4'(s);
      in_data = 4'(s);
      in_vld  = 1'b1;
      #1;
      check($sformatf("stream_rdy_%0d", s), 64'(in_rdy), 64'h1);
      tick();
      check($sformatf("stream_vld_%0d", s), 64'(out_vld), 64'(16'h1 << s));
      check($sformatf("stream_data_%0d", s), 64'(lane(out_data, s)), 64'(s));
    end
    in_vld = 1'b0;
    check("stream_cnt", 64'(disp_cnt), 64'd18);
    tick();

    // Stalled lane 3 must not block lanes 7 and 9
    out_rdy = 16'h0000;
    in_sel  = 4'd3;
    in_data = 4'hC;
    in_vld  = 1'b1;
    tick();
    out_rdy = 16'hFFF7;
    in_sel  = 4'd3;
    #1;
    check("indep_rdy3", 64'(in_rdy), 64'h0);
    in_sel  = 4'd7;
    in_data = 4'h1;
    #1;
    check("indep_rdy7", 64'(in_rdy), 64'h1);
    tick();
    in_sel  = 4'd9;
    in_data = 4'h2;
    #1;
    check("indep_rdy9", 64'(in_rdy), 64'h1);
    tick();
    in_vld = 1'b0;
    check("indep_vld", 64'(out_vld), 64'h0208);
    check("indep_lane3", 64'(lane(out_data, 3)), 64'hC);
    check("indep_lane7", 64'(lane(out_data, 7)), 64'h1);
    check("indep_lane9", 64'(lane(out_data, 9)), 64'h2);
    check("indep_cnt", 64'(disp_cnt), 64'd21);
    out_rdy = 16'hFFFF;
    tick();

    // Counter wrap: stream up to 16'hFFFF then one more beat
    in_vld = 1'b1;
    for (int i = 0; i < 65535 - 21; i++) begin
      in_sel  = 4'(i);
      in_data = 4'(i);
      tick();
    end
    in_vld = 1'b0;
    check("wrap_max", 64'(disp_cnt), 64'hFFFF);
    in_sel  = 4'd2;
    in_data = 4'h6;
    in_vld  = 1'b1;
    tick();
    in_vld = 1'b0;
    check("wrap_zero", 64'(disp_cnt), 64'h0);
    check("wrap_lane2", 64'(lane(out_data, 2)), 64'h6);
    tick();

`ifdef DEMUX16_BCAST_EN
    out_rdy  = 16'h0000;
    tick();
    in_bcast = 1'b1;
    in_sel   = 4'd4;
    in_data  = 4'h7;
    in_vld   = 1'b1;
    #1;
    check("bcast_rdy", 64'(in_rdy), 64'h1);
    tick();
    in_vld = 1'b0;
    check("bcast_vld", 64'(out_vld), 64'hFFFF);
    check("bcast_data", out_data, 64'h7777_7777_7777_7777);
    check("bcast_cnt", 64'(disp_cnt), 64'd1);
    in_data = 4'h5;
    in_vld  = 1'b1;
    out_rdy = 16'hFFFE;
    #1;
    check("bcast_stall_rdy", 64'(in_rdy), 64'h0);
    tick();
    check("bcast_stall_data", out_data, 64'h7777_7777_7777_7777);
    out_rdy = 16'hFFFF;
    #1;
    check("bcast_free_rdy", 64'(in_rdy), 64'h1);
    tick();
    in_vld   = 1'b0;
    in_bcast = 1'b0;
    check("bcast2_data", out_data, 64'h5555_5555_5555_5555);
    check("bcast2_cnt", 64'(disp_cnt), 64'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
